issue_queue_buffer: RTL and testbench
=====================================

// Module: issue_queue_buffer
// PURPOSE
//  In-order, multi-entry successor to the 4-wide operand-capture instruction buffer.
//  Accepts a decode group of up to LANES instructions per cycle and resolves operands from
//  regfile value/busy/owner or ROB result broadcast. Snoops the ROB every cycle for waiting
//  operands. Issues up to ISSUE_W ready instructions per cycle, oldest first, to the FXU/LSU/branch units.
// PARAMETERS
//  LANES    4   instructions per enqueue group
//  DEPTH    16  queue entries (power of 2, >= LANES)
//  ISSUE_W  2   max issues per cycle
//  DATA_W   16  operand width
//  TAG_W    4   ROB tag width (2**TAG_W ROB slots)
//  OPC_W    4   opcode width
//  REG_W    4   register index width
//  NUM_FU   4   functional units (0 fxu0, 1 fxu1, 2 lsu, 3 branch)
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    synchronous reset, active-high
//  flush          in   1                    discard all entries
//  in_valid       in   1                    enqueue group offered
//  in_ready       out  1                    free entries >= LANES
//  in_lane_valid  in   LANES                per-lane occupancy of group
//  in_opcode      in   LANES*OPC_W          opcodes
//  in_fu_sel      in   LANES*$clog2(NUM_FU) target unit per lane
//  in_rt          in   LANES*REG_W          destination register
//  in_uses_rb     in   LANES                operand B required
//  in_a_local_dep in   LANES                A produced by earlier lane of same group
//  in_a_local_tag in   LANES*TAG_W          ROB tag of that producer
//  in_b_local_dep in   LANES                as above, operand B
//  in_b_local_tag in   LANES*TAG_W
//  ra_value/ra_busy/ra_owner in LANES*DATA_W / LANES / LANES*TAG_W   regfile port A
//  rb_value/rb_busy/rb_owner in LANES*DATA_W / LANES / LANES*TAG_W   regfile port B
//  rob_valid      in   2**TAG_W             result ready per ROB slot
//  rob_values     in   2**TAG_W*DATA_W      result value per ROB slot
//  fu_full        in   NUM_FU               unit cannot accept this cycle
//  out_valid      out  ISSUE_W              issue slot k carries an instruction
//  out_opcode/out_fu_sel/out_rt  out  ISSUE_W*(OPC_W / $clog2(NUM_FU) / REG_W)
//  out_a_value/out_b_value       out  ISSUE_W*DATA_W   captured operands
// BEHAVIOUR
//  - Reset/flush: head=tail=count=0, all entry valid/ready bits 0. Outputs: out_valid=0,
//    in_ready=1, data outputs don't-care. Flush has priority over same-cycle enqueue/issue.
//  - Enqueue on in_valid&in_ready: valid lanes packed in lane order at tail; tail+=popcount
//    (mod DEPTH). in_ready = (DEPTH-count >= LANES) from registered count; no same-cycle credit.
//  - Operand resolve at enqueue, A (B identical via rb_*):
//    local_dep -> wait on local_tag;
//    ~busy -> ready, value=ra_value;
//    busy & rob_valid[owner] -> ready, value=rob_values[owner];
//    else -> wait on owner.
//    B with ~uses_rb -> ready, value 0.
//  - Wakeup: each cycle, every valid waiting operand with rob_valid[tag]=1 captures value and sets
//    ready. Captured values are issuable next cycle (no capture->issue bypass).
//  - Issue (combinational from registered state): slot k takes entry head+k. Issue k iff
//    k<count, slot k-1 issued, both operands ready, ~fu_full[fu], fu not used by an earlier slot
//    this cycle. Strictly in-order: first blocked entry stops issue.
//    Issued entries are consumed at the clock edge; head+=issued.
//  - count_next = count + enq - issued; simultaneous enq/issue legal. Pointers wrap mod DEPTH.
//  - Never overflows (in_ready gating). Issue with count=0 impossible (out_valid=0).
//  - A tag that never broadcasts blocks the head forever; flush is the recovery path.
// STRUCTURE
//  - Package iqb_pkg: fu enum (FU_FXU0..FU_BR), iqb_entry_t struct {valid, opcode, fu, rt,
//    a_rdy, a_tag, a_val, b_rdy, b_tag, b_val}, width localparams.
//  - Sub-module iqb_operand_slot: one operand's init-at-enqueue + ROB snoop. Instantiated
//    2*DEPTH times. Top holds pointers, count, lane packing, issue select.
// TESTING
//  1 Reset then idle: out_valid=0, in_ready=1. 4 lanes, all regs not busy (ra=5, rb=7), fu0 free
//    -> next cycle slot0 issues a=5 b=7; fu differs per lane -> two issued/cycle.
//  2 Lane1 a_local_dep tag=3. ROB[3] valid=1 value 0x1234 at cycle t
//    -> lane1 issues at t+1 with a=0x1234. Lane2 (ready) stays queued behind it.
//  3 Fill: 4 groups of 4 with fu_full=all 1 -> count=16, in_ready=0, in_valid ignored;
//    release fu_full -> drains in order, in_ready=1 once count<=12.
//  4 Structural: head two entries both fu=lsu -> only slot0 issues per cycle;
//    fu_full[lsu]=1 blocks both and all younger.
//  5 Wrap: 5 cycles enqueue 3 lanes/issue 2 -> tail wraps past 15, order/values preserved.
//  6 Flush with simultaneous in_valid and issuable head -> next cycle count=0, out_valid=0, nothing issued.

Source files
------------

// File: rtl/iqb_pkg.sv
// iqb_pkg: shared widths, types and operand-resolve helper for the issue queue buffer.
package iqb_pkg;
  localparam int LANES   = 4;
  localparam int DEPTH   = 16;
  localparam int ISSUE_W = 2;
  localparam int DATA_W  = 16;
  localparam int TAG_W   = 4;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 4;
  localparam int NUM_FU  = 4;
  localparam int FU_W    = $clog2(NUM_FU);
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int ROB_N   = 2 ** TAG_W;

  typedef enum logic [FU_W-1:0] {FU_FXU0, FU_FXU1, FU_LSU, FU_BR} fu_e;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    fu_e               fu;
    logic [REG_W-1:0]  rt;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
  } iqb_entry_t;

  // A same-group producer always waits, even if its ROB slot happens to look valid now.
  function automatic opnd_t resolve(input logic dep, input logic [TAG_W-1:0] ltag,
                                    input logic busy, input logic [TAG_W-1:0] owner,
                                    input logic [DATA_W-1:0] rf, input logic [ROB_N-1:0] rv,
                                    input logic [ROB_N*DATA_W-1:0] rvals);
    return dep ? opnd_t'{rdy: 1'b0, tag: ltag, val: '0} :
           !busy ? opnd_t'{rdy: 1'b1, tag: owner, val: rf} :
           rv[owner] ? opnd_t'{rdy: 1'b1, tag: owner, val: rvals[owner*DATA_W +: DATA_W]} :
           opnd_t'{rdy: 1'b0, tag: owner, val: '0};
  endfunction
endpackage

// File: rtl/iqb_operand_slot.sv
// iqb_operand_slot: one queued operand, initialised at enqueue and woken by ROB broadcast.
module iqb_operand_slot
  import iqb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    i_live,
  input  logic                    i_load,
  input  logic                    i_rdy,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic [DATA_W-1:0]       i_val,
  input  logic [ROB_N-1:0]        i_rob_valid,
  input  logic [ROB_N*DATA_W-1:0] i_rob_values,
  output logic                    o_rdy,
  output logic [DATA_W-1:0]       o_val
);
  logic              r_rdy;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_val;
  logic              w_wake;

  assign w_wake = i_live & ~r_rdy & i_rob_valid[r_tag];
  assign o_rdy  = r_rdy;
  assign o_val  = r_val;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rdy <= 1'b0;
    end else if (i_load) begin
      r_rdy <= i_rdy;
      r_tag <= i_tag;
      r_val <= i_val;
    end else if (w_wake) begin
      r_rdy <= 1'b1;
      r_val <= i_rob_values[r_tag*DATA_W +: DATA_W];
    end
  end
endmodule

// File: rtl/issue_queue_buffer.sv
// issue_queue_buffer: in-order operand-capturing issue queue, LANES-wide enqueue, ISSUE_W-wide issue.
module issue_queue_buffer
  import iqb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_valid,
  input  logic [LANES*OPC_W-1:0]    in_opcode,
  input  logic [LANES*FU_W-1:0]     in_fu_sel,
  input  logic [LANES*REG_W-1:0]    in_rt,
  input  logic [LANES-1:0]          in_uses_rb,
  input  logic [LANES-1:0]          in_a_local_dep,
  input  logic [LANES*TAG_W-1:0]    in_a_local_tag,
  input  logic [LANES-1:0]          in_b_local_dep,
  input  logic [LANES*TAG_W-1:0]    in_b_local_tag,
  input  logic [LANES*DATA_W-1:0]   ra_value,
  input  logic [LANES-1:0]          ra_busy,
  input  logic [LANES*TAG_W-1:0]    ra_owner,
  input  logic [LANES*DATA_W-1:0]   rb_value,
  input  logic [LANES-1:0]          rb_busy,
  input  logic [LANES*TAG_W-1:0]    rb_owner,
  input  logic [ROB_N-1:0]          rob_valid,
  input  logic [ROB_N*DATA_W-1:0]   rob_values,
  input  logic [NUM_FU-1:0]         fu_full,
  output logic [ISSUE_W-1:0]        out_valid,
  output logic [ISSUE_W*OPC_W-1:0]  out_opcode,
  output logic [ISSUE_W*FU_W-1:0]   out_fu_sel,
  output logic [ISSUE_W*REG_W-1:0]  out_rt,
  output logic [ISSUE_W*DATA_W-1:0] out_a_value,
  output logic [ISSUE_W*DATA_W-1:0] out_b_value
);
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [OPC_W-1:0]  r_opc [DEPTH];
  fu_e               r_fu  [DEPTH];
  logic [REG_W-1:0]  r_rt  [DEPTH];
  opnd_t             w_ra  [LANES];
  opnd_t             w_rb  [LANES];
  iqb_entry_t        w_new [LANES];
  iqb_entry_t        w_sel [DEPTH];
  logic [CW-1:0]     w_pos [LANES+1];
  logic [PW-1:0]     w_idx [ISSUE_W];
  logic [DATA_W-1:0] w_a_val [DEPTH];
  logic [DATA_W-1:0] w_b_val [DEPTH];
  logic [DEPTH-1:0]  w_load, w_a_rdy, w_b_rdy, w_iss_ent;
  logic [CW-1:0]     w_n_enq, w_n_iss;
  logic [NUM_FU-1:0] w_used;
  logic              w_enq, w_go;

  assign in_ready = r_count <= CW'(DEPTH - LANES);
  assign w_enq    = in_valid & in_ready;
  assign w_n_enq  = w_enq ? w_pos[LANES] : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_ra[l] = resolve(in_a_local_dep[l], in_a_local_tag[l*TAG_W +: TAG_W], ra_busy[l],
                             ra_owner[l*TAG_W +: TAG_W], ra_value[l*DATA_W +: DATA_W],
                             rob_valid, rob_values);
    assign w_rb[l] = in_uses_rb[l] ?
                     resolve(in_b_local_dep[l], in_b_local_tag[l*TAG_W +: TAG_W], rb_busy[l],
                             rb_owner[l*TAG_W +: TAG_W], rb_value[l*DATA_W +: DATA_W],
                             rob_valid, rob_values) :
                     opnd_t'{rdy: 1'b1, tag: '0, val: '0};
    assign w_new[l] = '{valid: in_lane_valid[l], opcode: in_opcode[l*OPC_W +: OPC_W],
                        fu: fu_e'(in_fu_sel[l*FU_W +: FU_W]), rt: in_rt[l*REG_W +: REG_W],
                        a_rdy: w_ra[l].rdy, a_tag: w_ra[l].tag, a_val: w_ra[l].val,
                        b_rdy: w_rb[l].rdy, b_tag: w_rb[l].tag, b_val: w_rb[l].val};
  end

  // Valid lanes are packed: lane l lands at tail + (number of valid lanes below l).
  always_comb begin
    w_pos[0] = '0;
    for (int l = 0; l < LANES; l++) w_pos[l+1] = w_pos[l] + CW'(in_lane_valid[l]);
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = '0;
      for (int l = 0; l < LANES; l++)
        if (w_enq && in_lane_valid[l] && PW'(CW'(r_tail) + w_pos[l]) == PW'(i)) w_sel[i] = w_new[l];
      w_load[i] = w_sel[i].valid;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    iqb_operand_slot u_a (.clk, .rst, .flush, .i_live(r_valid[i]), .i_load(w_load[i]),
      .i_rdy(w_sel[i].a_rdy), .i_tag(w_sel[i].a_tag), .i_val(w_sel[i].a_val),
      .i_rob_valid(rob_valid), .i_rob_values(rob_values), .o_rdy(w_a_rdy[i]), .o_val(w_a_val[i]));
    iqb_operand_slot u_b (.clk, .rst, .flush, .i_live(r_valid[i]), .i_load(w_load[i]),
      .i_rdy(w_sel[i].b_rdy), .i_tag(w_sel[i].b_tag), .i_val(w_sel[i].b_val),
      .i_rob_valid(rob_valid), .i_rob_values(rob_values), .o_rdy(w_b_rdy[i]), .o_val(w_b_val[i]));
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_out
    assign w_idx[k] = r_head + PW'(k);
    assign out_opcode[k*OPC_W +: OPC_W]    = r_opc[w_idx[k]];
    assign out_fu_sel[k*FU_W +: FU_W]      = r_fu[w_idx[k]];
    assign out_rt[k*REG_W +: REG_W]        = r_rt[w_idx[k]];
    assign out_a_value[k*DATA_W +: DATA_W] = w_a_val[w_idx[k]];
    assign out_b_value[k*DATA_W +: DATA_W] = w_b_val[w_idx[k]];
  end

  // w_go stays low once a slot is blocked, keeping issue strictly in order.
  always_comb begin
    w_go      = 1'b1;
    w_used    = '0;
    w_n_iss   = '0;
    w_iss_ent = '0;
    out_valid = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      w_go = w_go && !flush && CW'(k) < r_count && r_valid[w_idx[k]] && w_a_rdy[w_idx[k]] &&
             w_b_rdy[w_idx[k]] && !fu_full[r_fu[w_idx[k]]] && !w_used[r_fu[w_idx[k]]];
      out_valid[k] = w_go;
      if (w_go) begin
        w_used[r_fu[w_idx[k]]] = 1'b1;
        w_n_iss = w_n_iss + CW'(1);
        w_iss_ent[w_idx[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_iss);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= r_count + w_n_enq - w_n_iss;
      r_valid <= (r_valid & ~w_iss_ent) | w_load;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (w_load[i]) begin
        r_opc[i] <= w_sel[i].opcode;
        r_fu[i]  <= w_sel[i].fu;
        r_rt[i]  <= w_sel[i].rt;
      end
  end
endmodule

// File: tb/tb_issue_queue_buffer.sv
// tb_issue_queue_buffer: directed + random stimulus checked against a queue-based reference model.
module tb_issue_queue_buffer;
  import iqb_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready;
  logic [LANES-1:0] in_lane_valid, in_uses_rb, in_a_local_dep, in_b_local_dep, ra_busy, rb_busy;
  logic [LANES*OPC_W-1:0] in_opcode;
  logic [LANES*FU_W-1:0] in_fu_sel;
  logic [LANES*REG_W-1:0] in_rt;
  logic [LANES*TAG_W-1:0] in_a_local_tag, in_b_local_tag, ra_owner, rb_owner;
  logic [LANES*DATA_W-1:0] ra_value, rb_value;
  logic [ROB_N-1:0] rob_valid;
  logic [ROB_N*DATA_W-1:0] rob_values;
  logic [NUM_FU-1:0] fu_full;
  logic [ISSUE_W-1:0] out_valid;
  logic [ISSUE_W*OPC_W-1:0] out_opcode;
  logic [ISSUE_W*FU_W-1:0] out_fu_sel;
  logic [ISSUE_W*REG_W-1:0] out_rt;
  logic [ISSUE_W*DATA_W-1:0] out_a_value, out_b_value;

  issue_queue_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_opcode(in_opcode), .in_fu_sel(in_fu_sel), .in_rt(in_rt),
    .in_uses_rb(in_uses_rb), .in_a_local_dep(in_a_local_dep), .in_a_local_tag(in_a_local_tag),
    .in_b_local_dep(in_b_local_dep), .in_b_local_tag(in_b_local_tag),
    .ra_value(ra_value), .ra_busy(ra_busy), .ra_owner(ra_owner),
    .rb_value(rb_value), .rb_busy(rb_busy), .rb_owner(rb_owner),
    .rob_valid(rob_valid), .rob_values(rob_values), .fu_full(fu_full),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_fu_sel(out_fu_sel), .out_rt(out_rt),
    .out_a_value(out_a_value), .out_b_value(out_b_value));

  always #5 clk = ~clk;

  typedef struct {
    bit                r;
    logic [TAG_W-1:0]  t;
    logic [DATA_W-1:0] v;
  } op_t;
  typedef struct {
    logic [OPC_W-1:0] opc;
    logic [FU_W-1:0]  fu;
    logic [REG_W-1:0] rt;
    op_t              a, b;
  } m_t;

  m_t q[$];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] robv(input logic [TAG_W-1:0] t);
    return rob_values[t*DATA_W +: DATA_W];
  endfunction

  function automatic op_t res(input bit dep, input logic [TAG_W-1:0] lt, input bit busy,
                              input logic [TAG_W-1:0] own, input logic [DATA_W-1:0] rf);
    op_t o;
    o.r = 0; o.t = own; o.v = '0;
    if (dep) o.t = lt;
    else if (!busy) begin o.r = 1; o.v = rf; end
    else if (rob_valid[own]) begin o.r = 1; o.v = robv(own); end
    return o;
  endfunction

  function automatic m_t mk(input int l);
    m_t e;
    e.opc = in_opcode[l*OPC_W +: OPC_W];
    e.fu  = in_fu_sel[l*FU_W +: FU_W];
    e.rt  = in_rt[l*REG_W +: REG_W];
    e.a   = res(in_a_local_dep[l], in_a_local_tag[l*TAG_W +: TAG_W], ra_busy[l],
                ra_owner[l*TAG_W +: TAG_W], ra_value[l*DATA_W +: DATA_W]);
    e.b   = res(in_b_local_dep[l], in_b_local_tag[l*TAG_W +: TAG_W], rb_busy[l],
                rb_owner[l*TAG_W +: TAG_W], rb_value[l*DATA_W +: DATA_W]);
    if (!in_uses_rb[l]) begin e.b.r = 1; e.b.v = '0; end
    return e;
  endfunction

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic tick();
    bit [ISSUE_W-1:0] ev;
    bit [NUM_FU-1:0] used;
    bit go, rdy;
    int n;
    #1;
    rdy = q.size() <= DEPTH - LANES;
    chk("in_ready", in_ready, rdy);
    ev = 0; used = 0; n = 0; go = 1;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (go && !flush && k < q.size() && q[k].a.r && q[k].b.r && !fu_full[q[k].fu] && !used[q[k].fu]) begin
        ev[k] = 1; used[q[k].fu] = 1; n++;
      end else go = 0;
    end
    chk("out_valid", out_valid, ev);
    for (int k = 0; k < ISSUE_W; k++)
      if (ev[k])
        chk($sformatf("slot%0d", k),
            {out_opcode[k*OPC_W +: OPC_W], out_fu_sel[k*FU_W +: FU_W], out_rt[k*REG_W +: REG_W],
             out_a_value[k*DATA_W +: DATA_W], out_b_value[k*DATA_W +: DATA_W]},
            {q[k].opc, q[k].fu, q[k].rt, q[k].a.v, q[k].b.v});
    @(posedge clk);
    if (flush) q.delete();
    else begin
      repeat (n) void'(q.pop_front());
      foreach (q[i]) begin
        if (!q[i].a.r && rob_valid[q[i].a.t]) begin q[i].a.r = 1; q[i].a.v = robv(q[i].a.t); end
        if (!q[i].b.r && rob_valid[q[i].b.t]) begin q[i].b.r = 1; q[i].b.v = robv(q[i].b.t); end
      end
      if (in_valid && rdy)
        for (int l = 0; l < LANES; l++) if (in_lane_valid[l]) q.push_back(mk(l));
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_lane_valid = 0; in_opcode = 0; in_fu_sel = 0; in_rt = 0;
    in_uses_rb = 0; in_a_local_dep = 0; in_b_local_dep = 0; in_a_local_tag = 0; in_b_local_tag = 0;
    ra_value = 0; rb_value = 0; ra_busy = 0; rb_busy = 0; ra_owner = 0; rb_owner = 0;
    rob_valid = 0; rob_values = 0; fu_full = 0;
  endtask

  task automatic lane(input int l, input int fu, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    in_valid = 1;
    in_lane_valid[l] = 1;
    in_opcode[l*OPC_W +: OPC_W] = 4'($urandom);
    in_fu_sel[l*FU_W +: FU_W] = 2'(fu);
    in_rt[l*REG_W +: REG_W] = 4'($urandom);
    in_uses_rb[l] = 1;
    ra_value[l*DATA_W +: DATA_W] = a;
    rb_value[l*DATA_W +: DATA_W] = b;
  endtask

  task automatic rnd();
    flush = $urandom_range(0, 39) == 0;
    in_valid = $urandom_range(0, 2) != 0;
    in_lane_valid = 4'($urandom);
    in_opcode = 16'($urandom); in_fu_sel = 8'($urandom); in_rt = 16'($urandom);
    in_uses_rb = 4'($urandom);
    in_a_local_dep = 4'($urandom & $urandom); in_b_local_dep = 4'($urandom & $urandom);
    in_a_local_tag = 16'($urandom); in_b_local_tag = 16'($urandom);
    ra_value = {$urandom, $urandom}; rb_value = {$urandom, $urandom};
    ra_busy = 4'($urandom); rb_busy = 4'($urandom);
    ra_owner = 16'($urandom); rb_owner = 16'($urandom);
    rob_valid = 16'($urandom & $urandom & $urandom);
    for (int t = 0; t < ROB_N; t++) rob_values[t*DATA_W +: DATA_W] = 16'($urandom);
    fu_full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.delete();
    // 1: idle after reset, then a fully ready group issues two per cycle
    tick();
    for (int l = 0; l < LANES; l++) lane(l, l, 16'd5, 16'd7);
    tick();
    idle();
    #1;
    chk("t1_valid", out_valid, 2'b11);
    chk("t1_a", out_a_value[15:0], 16'd5);
    chk("t1_b", out_b_value[15:0], 16'd7);
    repeat (3) tick();
    // 2: lane1 waits on local tag 3, lane2 queued behind it
    lane(0, 0, 16'd1, 16'd2); lane(1, 1, 16'd3, 16'd4); lane(2, 2, 16'd5, 16'd6);
    in_a_local_dep[1] = 1; in_a_local_tag[7:4] = 4'd3;
    tick();
    idle();
    repeat (2) tick();
    rob_valid[3] = 1; rob_values[3*DATA_W +: DATA_W] = 16'h1234;
    #1 chk("t2_wait", out_valid, 2'b00);
    tick();
    idle();
    #1;
    chk("t2_valid", out_valid, 2'b11);
    chk("t2_a", out_a_value[15:0], 16'h1234);
    chk("t2_lane2", out_a_value[31:16], 16'd5);
    tick();
    // 3: fill to DEPTH with all units full, then drain
    for (int g = 0; g < 4; g++) begin
      idle(); fu_full = 4'hF;
      for (int l = 0; l < LANES; l++) lane(l, l, 16'(g * 16 + l), 16'(g * 16 + l + 100));
      tick();
    end
    #1 chk("t3_full", in_ready, 1'b0);
    tick();
    idle();
    repeat (9) tick();
    // 4: two LSU ops at the head serialise; LSU full blocks everything
    lane(0, 2, 16'd11, 16'd12); lane(1, 2, 16'd13, 16'd14);
    lane(2, 0, 16'd15, 16'd16); lane(3, 1, 16'd17, 16'd18);
    fu_full = 4'b0100;
    tick();
    idle(); fu_full = 4'b0100;
    #1 chk("t4_block", out_valid, 2'b00);
    tick();
    fu_full = 4'b0000;
    #1 chk("t4_single", out_valid, 2'b01);
    repeat (4) tick();
    // 5: enqueue 3 / issue 2 across the pointer wrap
    repeat (5) begin
      idle();
      for (int l = 0; l < 3; l++) lane(l, l, 16'($urandom), 16'($urandom));
      tick();
    end
    idle();
    repeat (6) tick();
    // 6: flush beats simultaneous enqueue and issue
    lane(0, 0, 16'd9, 16'd9); lane(1, 1, 16'd8, 16'd8);
    tick();
    idle();
    lane(0, 3, 16'd1, 16'd1); flush = 1;
    #1 chk("t6_flush_cycle", out_valid, 2'b00);
    tick();
    idle();
    #1;
    chk("t6_after_valid", out_valid, 2'b00);
    chk("t6_after_ready", in_ready, 1'b1);
    tick();
    // random phase
    repeat (400) begin
      rnd();
      tick();
    end
    idle();
    rob_valid = '1;
    for (int t = 0; t < ROB_N; t++) rob_values[t*DATA_W +: DATA_W] = 16'($urandom);
    repeat (12) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
